// File: rtl/icache_arbiter.sv
// rtl/icache_arbiter.sv - two-port round-robin arbiter for the instruction cache port with in-order response steering

package icache_arbiter_pkg;
    typedef logic [31:0] memaddr_t;
    typedef logic [31:0] word_t;
endpackage

module icache_arbiter
    import icache_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  memaddr_t                   m0_req_addr_i,
    input  logic                       m0_req_valid_i,
    output logic                       m0_req_ready_o,
    output memaddr_t                   m0_resp_addr_o,
    output word_t                      m0_resp_data_o,
    output logic                       m0_resp_valid_o,
    input  logic                       m0_resp_ready_i,

    input  memaddr_t                   m1_req_addr_i,
    input  logic                       m1_req_valid_i,
    output logic                       m1_req_ready_o,
    output memaddr_t                   m1_resp_addr_o,
    output word_t                      m1_resp_data_o,
    output logic                       m1_resp_valid_o,
    input  logic                       m1_resp_ready_i,

    output memaddr_t                   icache_req_addr_o,
    output logic                       icache_req_valid_o,
    input  logic                       icache_req_ready_i,
    input  memaddr_t                   icache_resp_addr_i,
    input  word_t                      icache_resp_data_i,
    input  logic                       icache_resp_valid_i,
    output logic                       icache_resp_ready_o,

    output logic [$clog2(DEPTH+1)-1:0] outstanding_o,
    output logic                       err_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Arbitration state: last granted port and the grant lock held while the
    // cache is looking at a request it has not yet taken.
    logic          last_q;
    logic          lock_q;
    logic          lock_id_q;

    // Order FIFO of owner IDs, one entry per accepted request.
    logic [DEPTH-1:0] own_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    logic          err_q;

    logic          grant;
    logic          grant_valid;
    logic          full;
    logic          empty;
    logic          head;
    logic          push;
    logic          pop;

    // Pick the port presented to the cache: a locked grant wins, otherwise a
    // lone requester, otherwise the port that did not win last time.
    always_comb begin
        grant = 1'b0;
        if (lock_q) begin
            grant = lock_id_q;
        end else if (m0_req_valid_i && m1_req_valid_i) begin
            grant = ~last_q;
        end else if (m1_req_valid_i) begin
            grant = 1'b1;
        end
        grant_valid = grant ? m1_req_valid_i : m0_req_valid_i;
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = own_q[rd_ptr_q];

    // Request path; a full FIFO blocks acceptance even if a pop happens in
    // the same cycle so that ready never depends on resp_ready.
    assign icache_req_valid_o = grant_valid & ~full & ~rst_i;
    assign icache_req_addr_o  = grant ? m1_req_addr_i : m0_req_addr_i;
    assign m0_req_ready_o     = ~grant & icache_req_ready_i & ~full & ~rst_i;
    assign m1_req_ready_o     =  grant & icache_req_ready_i & ~full & ~rst_i;
    assign push               = icache_req_valid_o & icache_req_ready_i;

    // Response path; with nothing outstanding the arbiter swallows stray
    // responses instead of stalling the cache.
    assign m0_resp_addr_o      = icache_resp_addr_i;
    assign m0_resp_data_o      = icache_resp_data_i;
    assign m1_resp_addr_o      = icache_resp_addr_i;
    assign m1_resp_data_o      = icache_resp_data_i;
    assign m0_resp_valid_o     = icache_resp_valid_i & ~empty & ~head & ~rst_i;
    assign m1_resp_valid_o     = icache_resp_valid_i & ~empty &  head & ~rst_i;
    assign icache_resp_ready_o = ~rst_i & (empty | (head ? m1_resp_ready_i : m0_resp_ready_i));
    assign pop                 = icache_resp_valid_i & icache_resp_ready_o & ~empty;

    assign outstanding_o = count_q;
    assign err_o         = err_q;

    // Round-robin history and grant lock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q    <= 1'b1;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (push) begin
            last_q    <= grant;
            lock_q    <= 1'b0;
        end else if (icache_req_valid_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= grant;
        end
    end

    // Owner FIFO: record the granted port on accept, retire on response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            own_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                own_q[wr_ptr_q] <= grant;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error for a response arriving with no owner on record.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (icache_resp_valid_i && empty) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_arbiter.sv
// tb/tb_icache_arbiter.sv - randomized and directed self-checking bench for icache_arbiter

module tb_icache_arbiter;
    import icache_arbiter_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_i;
    memaddr_t   m0_req_addr_i, m1_req_addr_i;
    logic       m0_req_valid_i, m1_req_valid_i;
    logic       m0_req_ready_o, m1_req_ready_o;
    memaddr_t   m0_resp_addr_o, m1_resp_addr_o;
    word_t      m0_resp_data_o, m1_resp_data_o;
    logic       m0_resp_valid_o, m1_resp_valid_o;
    logic       m0_resp_ready_i, m1_resp_ready_i;
    memaddr_t   icache_req_addr_o;
    logic       icache_req_valid_o;
    logic       icache_req_ready_i;
    memaddr_t   icache_resp_addr_i;
    word_t      icache_resp_data_i;
    logic       icache_resp_valid_i;
    logic       icache_resp_ready_o;
    logic [2:0] outstanding_o;
    logic       err_o;

    icache_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_addr_i(m0_req_addr_i), .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o),
        .m0_resp_addr_o(m0_resp_addr_o), .m0_resp_data_o(m0_resp_data_o),
        .m0_resp_valid_o(m0_resp_valid_o), .m0_resp_ready_i(m0_resp_ready_i),
        .m1_req_addr_i(m1_req_addr_i), .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o),
        .m1_resp_addr_o(m1_resp_addr_o), .m1_resp_data_o(m1_resp_data_o),
        .m1_resp_valid_o(m1_resp_valid_o), .m1_resp_ready_i(m1_resp_ready_i),
        .icache_req_addr_o(icache_req_addr_o), .icache_req_valid_o(icache_req_valid_o),
        .icache_req_ready_i(icache_req_ready_i), .icache_resp_addr_i(icache_resp_addr_i),
        .icache_resp_data_i(icache_resp_data_i), .icache_resp_valid_i(icache_resp_valid_i),
        .icache_resp_ready_o(icache_resp_ready_o), .outstanding_o(outstanding_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus knobs and requester / cache state
    int          prob[2];
    int          req_left[2];
    int          rr_prob[2];
    int          ready_prob;
    int          resp_prob;
    bit          stray_now;
    bit          pv[2];
    logic [31:0] pa[2];
    logic [31:0] next_addr[2];
    memaddr_t    cq[$];

    // reference model: owner order, per-port expected addresses, arbitration memory
    int          own_m[$];
    memaddr_t    exp_a0[$];
    memaddr_t    exp_a1[$];
    int          last_m;
    int          held_m;
    bit          err_m;

    // observations
    int          acc_log[$];
    int          rcnt[2];
    int          max_out;
    logic [31:0] s_req_addr;
    bit          s_rdy[2];
    bit          s_rv[2];
    bit          s_resp_rdy;
    int          s_out;
    bit          s_err;

    function automatic word_t fdata(input memaddr_t a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        int       cnt;
        bit       full;
        bit       empty;
        int       g;
        bit       exp_rqv;
        int       head;
        bit       er[2];
        bit       exp_rr;
        bit       rr[2];
        bit       crdy;
        bit       rv;
        bit       drdy[2];
        bit       drv[2];
        memaddr_t dra[2];
        word_t    drd[2];
        memaddr_t front;

        for (int n = 0; n < 2; n++) begin
            if (!pv[n] && req_left[n] > 0 && int'($urandom_range(99)) < prob[n]) begin
                pv[n] = 1'b1;
                pa[n] = next_addr[n];
                next_addr[n] = next_addr[n] + 32'd4;
                req_left[n]--;
            end
            rr[n] = int'($urandom_range(99)) < rr_prob[n];
        end
        m0_req_valid_i = pv[0];
        m0_req_addr_i  = pa[0];
        m1_req_valid_i = pv[1];
        m1_req_addr_i  = pa[1];
        crdy = int'($urandom_range(99)) < ready_prob;
        icache_req_ready_i = crdy;
        rv = 1'b0;
        icache_resp_addr_i = '0;
        icache_resp_data_i = '0;
        if (stray_now) begin
            rv = 1'b1;
            icache_resp_addr_i = 32'hDEAD_BEE0;
            icache_resp_data_i = fdata(32'hDEAD_BEE0);
        end else if (cq.size() > 0 && int'($urandom_range(99)) < resp_prob) begin
            rv = 1'b1;
            icache_resp_addr_i = cq[0];
            icache_resp_data_i = fdata(cq[0]);
        end
        icache_resp_valid_i = rv;
        m0_resp_ready_i = rr[0];
        m1_resp_ready_i = rr[1];

        @(negedge clk);
        cnt   = own_m.size();
        full  = (cnt == DEPTH);
        empty = (cnt == 0);
        if (held_m >= 0)          g = held_m;
        else if (pv[0] && pv[1])  g = 1 - last_m;
        else                      g = pv[1] ? 1 : 0;
        exp_rqv = pv[g] && !full;
        drdy[0] = m0_req_ready_o;  drdy[1] = m1_req_ready_o;
        drv[0]  = m0_resp_valid_o; drv[1]  = m1_resp_valid_o;
        dra[0]  = m0_resp_addr_o;  dra[1]  = m1_resp_addr_o;
        drd[0]  = m0_resp_data_o;  drd[1]  = m1_resp_data_o;

        chk("req_valid", 32'(icache_req_valid_o), 32'(exp_rqv));
        if (exp_rqv) chk("req_addr", icache_req_addr_o, pa[g]);
        head = empty ? 0 : own_m[0];
        for (int n = 0; n < 2; n++) begin
            if (pv[n]) chk($sformatf("m%0d_req_ready", n), 32'(drdy[n]), 32'((g == n) && crdy && !full));
            er[n] = rv && !empty && (head == n);
            chk($sformatf("m%0d_resp_valid", n), 32'(drv[n]), 32'(er[n]));
            if (er[n]) begin
                front = (n == 0) ? exp_a0[0] : exp_a1[0];
                chk($sformatf("m%0d_resp_addr", n), dra[n], front);
                chk($sformatf("m%0d_resp_data", n), drd[n], fdata(front));
            end
        end
        exp_rr = empty ? 1'b1 : rr[head];
        chk("resp_ready", 32'(icache_resp_ready_o), 32'(exp_rr));
        chk("outstanding", 32'(outstanding_o), 32'(cnt));
        chk("err", 32'(err_o), 32'(err_m));

        s_req_addr = icache_req_addr_o;
        s_rdy      = drdy;
        s_rv       = drv;
        s_resp_rdy = icache_resp_ready_o;
        s_out      = int'(outstanding_o);
        s_err      = err_o;
        for (int n = 0; n < 2; n++) begin
            if (drdy[n] && pv[n]) acc_log.push_back(n);
            if (drv[n] && rr[n]) rcnt[n]++;
        end
        if (s_out > max_out) max_out = s_out;

        if (rv && empty) err_m = 1'b1;
        if (rv && !empty && exp_rr) begin
            void'(own_m.pop_front());
            void'(cq.pop_front());
            if (head == 0) void'(exp_a0.pop_front());
            else           void'(exp_a1.pop_front());
        end
        if (exp_rqv && crdy) begin
            own_m.push_back(g);
            cq.push_back(pa[g]);
            if (g == 0) exp_a0.push_back(pa[g]);
            else        exp_a1.push_back(pa[g]);
            last_m = g;
            held_m = -1;
            pv[g]  = 1'b0;
        end else if (exp_rqv) begin
            held_m = g;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        m0_req_valid_i = 1'b1;
        m1_req_valid_i = 1'b1;
        icache_req_ready_i = 1'b1;
        icache_resp_valid_i = 1'b1;
        m0_resp_ready_i = 1'b1;
        m1_resp_ready_i = 1'b1;
        #2;
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_req_valid", 32'(icache_req_valid_o), 32'd0);
        chk("rst_m0_req_ready", 32'(m0_req_ready_o), 32'd0);
        chk("rst_m1_req_ready", 32'(m1_req_ready_o), 32'd0);
        chk("rst_m0_resp_valid", 32'(m0_resp_valid_o), 32'd0);
        chk("rst_m1_resp_valid", 32'(m1_resp_valid_o), 32'd0);
        chk("rst_resp_ready", 32'(icache_resp_ready_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        m0_req_valid_i = 1'b0;
        m1_req_valid_i = 1'b0;
        icache_resp_valid_i = 1'b0;
        own_m.delete(); exp_a0.delete(); exp_a1.delete(); cq.delete(); acc_log.delete();
        last_m = 1; held_m = -1; err_m = 1'b0;
        pv[0] = 1'b0; pv[1] = 1'b0;
        next_addr[0] = 32'h00; next_addr[1] = 32'h80;
        prob = '{0, 0}; req_left = '{0, 0}; rr_prob = '{100, 100};
        ready_prob = 100; resp_prob = 100; stray_now = 1'b0;
        rcnt = '{0, 0}; max_out = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst_i = 1'b1;
        m0_req_addr_i = '0; m1_req_addr_i = '0;
        icache_resp_addr_i = '0; icache_resp_data_i = '0;
        #3;
        do_reset();

        // single port: 8 sequential addresses from port 0
        prob = '{100, 0}; req_left = '{8, 0};
        repeat (30) cycle();
        chk("single_p0_resps", 32'(rcnt[0]), 32'd8);
        chk("single_p1_resps", 32'(rcnt[1]), 32'd0);
        chk("single_max_out_ok", 32'(max_out <= DEPTH), 32'd1);
        chk("single_next_addr", next_addr[0], 32'h20);

        // contention: grants alternate starting with port 0
        do_reset();
        prob = '{100, 100}; req_left = '{3, 3};
        repeat (6) cycle();
        chk("fair_count", 32'(acc_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            chk($sformatf("fair_grant%0d", i), 32'((acc_log.size() > i) ? acc_log[i] : -1), 32'(i % 2));
        repeat (10) cycle();
        chk("fair_p0_resps", 32'(rcnt[0]), 32'd3);
        chk("fair_p1_resps", 32'(rcnt[1]), 32'd3);

        // lock: port 0 held while port 1 arrives, port 1 only after port 0 accepted
        do_reset();
        prob = '{100, 100}; req_left = '{1, 0};
        cycle();
        ready_prob = 0; req_left[0] = 1;
        cycle();
        chk("lock_addr_c1", s_req_addr, 32'h04);
        req_left[1] = 1;
        cycle();
        chk("lock_addr_c2", s_req_addr, 32'h04);
        cycle();
        chk("lock_addr_c3", s_req_addr, 32'h04);
        acc_log.delete();
        ready_prob = 100;
        cycle();
        cycle();
        chk("lock_order_len", 32'(acc_log.size()), 32'd2);
        chk("lock_first", 32'((acc_log.size() > 0) ? acc_log[0] : -1), 32'd0);
        chk("lock_second", 32'((acc_log.size() > 1) ? acc_log[1] : -1), 32'd1);
        repeat (6) cycle();

        // full: four accepted, fifth blocked, resumes the cycle after a pop
        do_reset();
        prob = '{100, 0}; req_left = '{6, 0}; resp_prob = 0;
        repeat (4) cycle();
        cycle();
        chk("full_ready", 32'(s_rdy[0]), 32'd0);
        chk("full_outstanding", 32'(s_out), 32'd4);
        resp_prob = 100;
        cycle();
        chk("full_ready_on_pop", 32'(s_rdy[0]), 32'd0);
        resp_prob = 0;
        cycle();
        chk("full_resume", 32'(s_rdy[0]), 32'd1);
        resp_prob = 100;
        repeat (15) cycle();

        // response backpressure from head owner port 1
        do_reset();
        prob = '{100, 100}; req_left = '{0, 1}; resp_prob = 0;
        cycle();
        req_left[0] = 1;
        cycle();
        rr_prob = '{100, 0}; resp_prob = 100;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_resp_ready", 32'(s_resp_rdy), 32'd0);
            chk("bp_p0_resp", 32'(s_rv[0]), 32'd0);
        end
        rr_prob = '{100, 100};
        repeat (5) cycle();
        chk("bp_p1_resps", 32'(rcnt[1]), 32'd1);
        chk("bp_p0_resps", 32'(rcnt[0]), 32'd1);

        // randomized traffic
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            prob[0] = int'($urandom_range(100));
            prob[1] = int'($urandom_range(100));
            req_left = '{1000, 1000};
            ready_prob = int'($urandom_range(100, 20));
            resp_prob  = int'($urandom_range(100, 20));
            rr_prob[0] = int'($urandom_range(100, 30));
            rr_prob[1] = int'($urandom_range(100, 30));
            repeat (200) cycle();
        end
        req_left = '{0, 0}; ready_prob = 100; resp_prob = 100; rr_prob = '{100, 100};
        guard = 0;
        while ((own_m.size() > 0 || pv[0] || pv[1]) && guard < 200) begin
            cycle();
            guard++;
        end
        chk("rand_drained", 32'(own_m.size()), 32'd0);

        // stray response after reset with requests outstanding
        do_reset();
        prob = '{100, 0}; req_left = '{3, 0}; resp_prob = 0;
        repeat (4) cycle();
        chk("stray_pre_outstanding", 32'(s_out), 32'd3);
        do_reset();
        cycle();
        chk("stray_post_rst_outstanding", 32'(s_out), 32'd0);
        stray_now = 1'b1;
        cycle();
        chk("stray_resp_ready", 32'(s_resp_rdy), 32'd1);
        chk("stray_err_same_cycle", 32'(s_err), 32'd0);
        stray_now = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stray_err_sticky", 32'(s_err), 32'd1);
        end
        do_reset();
        cycle();
        chk("stray_err_cleared", 32'(s_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_arbiter.md
# icache_arbiter

Shares the single `instruction_cache` request/response port between two requesters: port 0 (the fetch stage) and port 1 (a debug/loader master). It arbitrates requests round-robin, records which requester owns each in-flight request in an order FIFO, and steers in-order cache responses back to the owner. It sits between the requesters and `instruction_cache`. The request and response paths are combinational, so it adds no latency.

## Interface
- `DEPTH`, default 4: maximum outstanding accepted requests awaiting response; power of two, ≥2.
- `clk_i`  in  1  clock; all state updates on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `m0_req_addr_i` / `m1_req_addr_i`  in  memaddr_t  requester address.
- `m0_req_valid_i` / `m1_req_valid_i`  in  1  request valid; held with address stable until ready.
- `m0_req_ready_o` / `m1_req_ready_o`  out  1  request accepted this cycle when high with valid.
- `m0_resp_addr_o` / `m1_resp_addr_o`  out  memaddr_t  response address (copy of `icache_resp_addr_i`).
- `m0_resp_data_o` / `m1_resp_data_o`  out  word_t  response data (copy of `icache_resp_data_i`).
- `m0_resp_valid_o` / `m1_resp_valid_o`  out  1  response valid for this requester.
- `m0_resp_ready_i` / `m1_resp_ready_i`  in  1  requester can take the response.
- `icache_req_addr_o`  out  memaddr_t  address of the granted requester.
- `icache_req_valid_o`  out  1  granted requester valid, gated by FIFO space.
- `icache_req_ready_i`  in  1  cache accepts request.
- `icache_resp_addr_i`  in  memaddr_t  response address.
- `icache_resp_data_i`  in  word_t  response data.
- `icache_resp_valid_i`  in  1  response valid.
- `icache_resp_ready_o`  out  1  response consumed.
- `outstanding_o`  out  $clog2(DEPTH+1)  count of accepted, unanswered requests.
- `err_o`  out  1  sticky; set by a response arriving with an empty FIFO.

## Operation
- State:
  - `last_q`: last port granted. Reset value is 1, so port 0 wins the first tie.
  - `lock_q`/`lock_id_q`: grant lock.
  - Order FIFO of 1-bit owner IDs: `DEPTH` entries, read/write pointers of width $clog2(DEPTH), and count.
  - `err_q`.
- Grant selection, combinational:
  - If `lock_q` is set, grant `lock_id_q`.
  - Otherwise, if only one port is valid, grant it.
  - Otherwise, if both are valid, grant `~last_q`.
  - If no port is valid, drive `icache_req_valid_o`=0.
- `full` = (count == DEPTH).
- `icache_req_valid_o` = granted valid & ~full. The address mux follows the grant.
- `mN_req_ready_o` = (grant==N) & icache_req_ready_i & ~full.
- Accept (push) = `icache_req_valid_o` & `icache_req_ready_i`. On accept:
  - Write the grant ID at the write pointer.
  - Set `last_q` ← grant.
  - Clear the lock.
- Grant lock: if `icache_req_valid_o` is high and the cache is not ready, set `lock_q`=1 and `lock_id_q`=grant. The grant then cannot change while the cache sees a pending request.
- Response steering, with head = FIFO owner ID at the read pointer:
  - `mN_resp_valid_o` = icache_resp_valid_i & ~empty & (head==N).
  - `icache_resp_ready_o` = empty ? 1 : m[head]_resp_ready_i. An empty FIFO drains stray responses.
  - Pop on `icache_resp_valid_i` & `icache_resp_ready_o` & ~empty.
- Stray response: `icache_resp_valid_i` with the FIFO empty sets `err_q`. `err_q` clears only on reset.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither. Pointers wrap modulo `DEPTH`.
- Full gating: a full FIFO blocks acceptance even when a pop occurs in the same cycle. This keeps ready free of any combinational dependency on `resp_ready`.

## Timing
- Reset, asynchronous, immediate:
  - count=0, pointers=0, `last_q`=1, `lock_q`=0, `err_o`=0, `outstanding_o`=0.
  - All `*_valid_o` and `*_ready_o` are 0 while `rst_i` is high.
  - `icache_resp_ready_o` is 0 during reset and 1 on the first cycle after, because the FIFO is empty.
- Reset mid-operation discards all ownership records. The cache is reset on the same `rst_i`.
- Request path: zero-cycle latency from `mN_req_valid_i` to `icache_req_valid_o`.
- Response path: zero-cycle latency from `icache_resp_valid_i` to `mN_resp_valid_o`.
- Accept/pop effects are visible in `outstanding_o` the cycle after the handshake.
- Fairness: with both ports continuously valid and the cache always ready, grants alternate 0,1,0,1 every cycle.
- Backpressure: a requester holding `resp_ready`=0 stalls the cache response stream for both ports (in-order, no bypass).

## Test plan
- Single port: port 0 issues 8 sequential addresses 0x00..0x1C, cache always ready. Required:
  - port 0 receives 8 in-order responses;
  - port 1 `resp_valid` never asserts;
  - `outstanding_o` never exceeds `DEPTH`.
- Contention: both ports valid for 6 cycles after reset, port 0 at 0x00.., port 1 at 0x80... Required: grants alternate 0,1,0,1,0,1 and each response returns to the port that issued its address.
- Lock: port 0 valid while `icache_req_ready_i`=0 for 3 cycles; port 1 asserts valid in cycle 2. Required:
  - `icache_req_addr_o` stays at port 0's address until accepted;
  - port 1 is granted next.
- Full: `DEPTH`=4, cache accepts 4 requests and withholds responses. Required:
  - 5th request sees `req_ready_o`=0, `outstanding_o`=4;
  - after one response pops, acceptance resumes the following cycle.
- Response backpressure: head owner port 1 holds `resp_ready`=0 for 5 cycles. Required: `icache_resp_ready_o`=0 for those 5 cycles and port 0 gets no response.
- Stray/reset: assert `rst_i` with 3 outstanding, release, then drive one `icache_resp_valid_i`. Required:
  - `outstanding_o`=0 after reset;
  - response drained with `icache_resp_ready_o`=1;
  - `err_o`=1 from the next cycle until the following reset.
